// File: rtl/nvm_pkg.sv
// Shared types and constants for the newspaper vending sequencer.
// Coin encodings, FSM states and nickel values live here.
package nvm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Credit value of each accepted coin, in nickels
    localparam logic [1:0] VAL_5  = 2'd1;
    localparam logic [1:0] VAL_10 = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_IDLE,
        ST_VEND,
        ST_PAYOUT
    } state_e;

    function automatic logic [1:0] coin_value(input logic [1:0] c);
        logic [1:0] v;
        v = 2'd0;
        if (c == COIN_5) begin
            v = VAL_5;
        end else if (c == COIN_10) begin
            v = VAL_10;
        end
        return v;
    endfunction

endpackage

// File: rtl/nvm_timeout_ctr.sv
// Clear/enable cycle counter with a terminal-count flag.
// Holds at MAX-1 so it never wraps while waiting.
module nvm_timeout_ctr #(
    parameter int MAX = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int W = (MAX > 2) ? $clog2(MAX) : 1;

    logic [W-1:0] cnt_q;

    assign tc_o = (cnt_q == W'(MAX - 1));

    // Count enabled cycles; clear has priority, saturate at terminal count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/nvm_vend_ctrl.sv
// Vend sequencer: coin credit, dispenser handshake, change pulses,
// stock tracking and sticky dispenser-timeout fault.
module nvm_vend_ctrl
    import nvm_pkg::*;
#(
    parameter int PRICE   = 3,
    parameter int STOCK_W = 8,
    parameter int TIMEOUT = 64,
    parameter int CW      = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [1:0]         coin_i,
    input  logic               cancel_i,
    input  logic               stock_load_i,
    input  logic [STOCK_W-1:0] stock_in_i,
    input  logic               disp_done_i,
    output logic               dispense_req_o,
    output logic               change_pulse_o,
    output logic               coin_reject_o,
    output logic [CW-1:0]      credit_o,
    output logic [STOCK_W-1:0] stock_o,
    output logic               sold_out_o,
    output logic               fault_o,
    output logic               busy_o
);

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

    state_e             state_q, state_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic [CW-1:0]      change_q, change_d;
    logic [STOCK_W-1:0] stock_q, stock_d;
    logic               fault_q, fault_d;
    logic               reject_d;

    logic               dispense_req_q;
    logic               change_pulse_q;
    logic               coin_reject_q;
    logic               sold_out_q;
    logic               busy_q;

    logic               coin_any;
    logic               coin_ok;
    logic [CW-1:0]      sum;
    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_tc;

    assign coin_any = (coin_i != COIN_NONE);
    assign coin_ok  = (coin_i == COIN_5) || (coin_i == COIN_10);
    assign sum      = credit_q + CW'(coin_value(coin_i));

    // Timer runs only while staying in VEND; cleared on entry and exit
    assign tmr_en  = (state_q == ST_VEND);
    assign tmr_clr = (state_q != ST_VEND) || (state_d != ST_VEND);

    nvm_timeout_ctr #(
        .MAX (TIMEOUT)
    ) u_tmr (
        .clk_i (clock_i),
        .rst_i (reset_i),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    // Next-state, credit, change, stock and fault logic
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        stock_d  = stock_q;
        fault_d  = fault_q;
        reject_d = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                reject_d = coin_any;
                if (stock_load_i && stock_in_i != '0 && !fault_q) begin
                    stock_d = stock_in_i;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cancel_i) begin
                    reject_d = coin_any;
                    if (credit_q != '0) begin
                        change_d = credit_q;
                        credit_d = '0;
                        state_d  = ST_PAYOUT;
                    end
                end else if (coin_ok) begin
                    if (sum >= PRICE_C) begin
                        change_d = sum - PRICE_C;
                        credit_d = '0;
                        state_d  = ST_VEND;
                    end else begin
                        credit_d = sum;
                    end
                end else begin
                    reject_d = (coin_i == COIN_BAD);
                    if (stock_load_i && credit_q == '0) begin
                        stock_d = stock_in_i;
                        if (stock_in_i == '0) begin
                            state_d = ST_EMPTY;
                        end
                    end
                end
            end
            ST_VEND: begin
                reject_d = coin_any;
                if (disp_done_i) begin
                    stock_d = stock_q - STOCK_W'(1);
                    if (change_q != '0) begin
                        state_d = ST_PAYOUT;
                    end else if (stock_d == '0 || fault_q) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmr_tc) begin
                    fault_d  = 1'b1;
                    change_d = change_q + PRICE_C;
                    state_d  = ST_PAYOUT;
                end
            end
            ST_PAYOUT: begin
                reject_d = coin_any;
                if (change_q != '0) begin
                    change_d = change_q - CW'(1);
                end
                if (change_q <= CW'(1)) begin
                    if (stock_q == '0 || fault_q) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_EMPTY;
            credit_q <= '0;
            change_q <= '0;
            stock_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            stock_q  <= stock_d;
            fault_q  <= fault_d;
        end
    end

    // Registered outputs derived from the upcoming state
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            dispense_req_q <= 1'b0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            sold_out_q     <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            dispense_req_q <= (state_d == ST_VEND);
            change_pulse_q <= (state_d == ST_PAYOUT);
            coin_reject_q  <= reject_d;
            sold_out_q     <= (stock_d == '0);
            busy_q         <= (state_d == ST_VEND) ||
                              (state_d == ST_PAYOUT);
        end
    end

    assign dispense_req_o = dispense_req_q;
    assign change_pulse_o = change_pulse_q;
    assign coin_reject_o  = coin_reject_q;
    assign credit_o       = credit_q;
    assign stock_o        = stock_q;
    assign sold_out_o     = sold_out_q;
    assign fault_o        = fault_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_nvm_vend_ctrl.sv
// Directed bench for nvm_vend_ctrl (PRICE=3, TIMEOUT=8).
// Each task drives one scenario and checks hand-computed values.
module tb_nvm_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin;
    logic       cancel;
    logic       sload;
    logic [7:0] sin;
    logic       done;
    logic       req;
    logic       pulse;
    logic       rej;
    logic [3:0] credit;
    logic [7:0] stock;
    logic       sold;
    logic       fault;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nvm_vend_ctrl #(
        .PRICE   (3),
        .STOCK_W (8),
        .TIMEOUT (8),
        .CW      (4)
    ) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .coin_i         (coin),
        .cancel_i       (cancel),
        .stock_load_i   (sload),
        .stock_in_i     (sin),
        .disp_done_i    (done),
        .dispense_req_o (req),
        .change_pulse_o (pulse),
        .coin_reject_o  (rej),
        .credit_o       (credit),
        .stock_o        (stock),
        .sold_out_o     (sold),
        .fault_o        (fault),
        .busy_o         (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
        coin   = 2'b00;
        cancel = 1'b0;
        sload  = 1'b0;
        done   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        coin = 2'b00; cancel = 1'b0; sload = 1'b0;
        sin = 8'd0; done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // flags: {req, pulse, rej, busy, sold, fault}
    task automatic chk(input string name, input logic [5:0] exp_f,
                       input logic [3:0] exp_c, input logic [7:0] exp_s);
        logic [5:0] got_f;
        got_f = {req, pulse, rej, busy, sold, fault};
        checks++;
        if (got_f !== exp_f || credit !== exp_c || stock !== exp_s) begin
            errors++;
            $display("FAIL %s flags(req,pls,rej,busy,sold,flt) got %b want %b credit got %0d want %0d stock got %0d want %0d",
                     name, got_f, exp_f, credit, exp_c, stock, exp_s);
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset", 6'b000010, 4'd0, 8'd0);
    endtask

    task automatic test_basic_vend();
        sload = 1'b1; sin = 8'd5; step();
        chk("load5", 6'b000000, 4'd0, 8'd5);
        coin = 2'b01; step();
        chk("coin1", 6'b000000, 4'd1, 8'd5);
        coin = 2'b01; step();
        chk("coin2", 6'b000000, 4'd2, 8'd5);
        coin = 2'b01; step();
        chk("coin3_vend", 6'b100100, 4'd0, 8'd5);
        step();
        chk("vend_wait", 6'b100100, 4'd0, 8'd5);
        done = 1'b1; step();
        chk("vend_done", 6'b000000, 4'd0, 8'd4);
        coin = 2'b01; step();
        chk("idle_accept", 6'b000000, 4'd1, 8'd4);
        cancel = 1'b1; step();
        chk("cancel1_pulse", 6'b010100, 4'd0, 8'd4);
        step();
        chk("cancel1_end", 6'b000000, 4'd0, 8'd4);
    endtask

    task automatic test_change();
        sload = 1'b1; sin = 8'd2; step();
        chk("load2", 6'b000000, 4'd0, 8'd2);
        coin = 2'b10; step();
        chk("ten1", 6'b000000, 4'd2, 8'd2);
        coin = 2'b10; step();
        chk("ten2_vend", 6'b100100, 4'd0, 8'd2);
        done = 1'b1; step();
        chk("change_pulse", 6'b010100, 4'd0, 8'd1);
        step();
        chk("change_end", 6'b000000, 4'd0, 8'd1);
    endtask

    task automatic test_cancel();
        coin = 2'b10; step();
        chk("cx_ten", 6'b000000, 4'd2, 8'd1);
        coin = 2'b01; cancel = 1'b1; step();
        chk("cx_pulse1", 6'b011100, 4'd0, 8'd1);
        step();
        chk("cx_pulse2", 6'b010100, 4'd0, 8'd1);
        step();
        chk("cx_end", 6'b000000, 4'd0, 8'd1);
    endtask

    task automatic test_bad_coin();
        coin = 2'b11; step();
        chk("bad_idle0", 6'b001000, 4'd0, 8'd1);
        coin = 2'b01; step();
        chk("good_after_bad", 6'b000000, 4'd1, 8'd1);
        coin = 2'b11; step();
        chk("bad_idle1", 6'b001000, 4'd1, 8'd1);
        cancel = 1'b1; step();
        chk("bad_refund", 6'b010100, 4'd0, 8'd1);
        step();
        chk("bad_refund_end", 6'b000000, 4'd0, 8'd1);
    endtask

    task automatic test_sold_out();
        for (int i = 0; i < 3; i++) begin
            coin = 2'b01; step();
        end
        chk("last_vend", 6'b100100, 4'd0, 8'd1);
        done = 1'b1; step();
        chk("sold_out", 6'b000010, 4'd0, 8'd0);
        coin = 2'b01; step();
        chk("empty_rej5", 6'b001010, 4'd0, 8'd0);
        sload = 1'b1; sin = 8'd0; coin = 2'b10; step();
        chk("empty_load0", 6'b001010, 4'd0, 8'd0);
    endtask

    task automatic test_timeout_edge();
        sload = 1'b1; sin = 8'd2; step();
        coin = 2'b10; step();
        coin = 2'b01; step();
        chk("te_vend", 6'b100100, 4'd0, 8'd2);
        for (int i = 0; i < 7; i++) begin
            step();
        end
        chk("te_last_cycle", 6'b100100, 4'd0, 8'd2);
        done = 1'b1; step();
        chk("te_done_wins", 6'b000000, 4'd0, 8'd1);
    endtask

    task automatic test_timeout();
        sload = 1'b1; sin = 8'd3; step();
        coin = 2'b10; step();
        coin = 2'b10; step();
        chk("to_vend", 6'b100100, 4'd0, 8'd3);
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (req !== 1'b1 || fault !== 1'b0) begin
                errors++;
                $display("FAIL to_wait%0d req got %b want 1 fault got %b want 0",
                         i, req, fault);
            end
        end
        step();
        chk("to_fault", 6'b010101, 4'd0, 8'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_pulse", 6'b010101, 4'd0, 8'd3);
        end
        step();
        chk("to_end", 6'b000001, 4'd0, 8'd3);
        coin = 2'b01; step();
        chk("to_empty_rej", 6'b001001, 4'd0, 8'd3);
    endtask

    task automatic test_reset_mid_payout();
        do_reset();
        sload = 1'b1; sin = 8'd3; step();
        coin = 2'b10; step();
        cancel = 1'b1; step();
        chk("rp_pulse", 6'b010100, 4'd0, 8'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("rp_async", 6'b000010, 4'd0, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        coin = 2'b01; step();
        chk("rp_empty", 6'b001010, 4'd0, 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic_vend();
        test_change();
        test_cancel();
        test_bad_coin();
        test_sold_out();
        do_reset();
        test_timeout_edge();
        test_timeout();
        test_reset_mid_payout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
